// File: rtl/tof5_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tof5_pkg                                                        |
// | Purpose  : Shared definitions for the 2-out-of-5 frame decoder: the ten    |
// |            codeword constants, the invalid-digit marker, the default frame |
// |            depth, the decoder FSM state type and a codeword lookup         |
// |            function returning {valid, digit}.                              |
// | Ports    : none (package)                                                  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package tof5_pkg;

  localparam int NDIG_DEFAULT = 4;

  localparam logic [3:0] INVALID_DIGIT = 4'hF;

  localparam logic [4:0] CODE_0 = 5'b00011;
  localparam logic [4:0] CODE_1 = 5'b00101;
  localparam logic [4:0] CODE_2 = 5'b00110;
  localparam logic [4:0] CODE_3 = 5'b01001;
  localparam logic [4:0] CODE_4 = 5'b01010;
  localparam logic [4:0] CODE_5 = 5'b01100;
  localparam logic [4:0] CODE_6 = 5'b10001;
  localparam logic [4:0] CODE_7 = 5'b10010;
  localparam logic [4:0] CODE_8 = 5'b10100;
  localparam logic [4:0] CODE_9 = 5'b11000;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } state_t;

  // Returns {in_map, digit}; digit is INVALID_DIGIT for unmapped codewords.
  function automatic logic [4:0] tof5_decode(input logic [4:0] code);
    logic [4:0] result;
    case (code)
      CODE_0:  result = {1'b1, 4'd0};
      CODE_1:  result = {1'b1, 4'd1};
      CODE_2:  result = {1'b1, 4'd2};
      CODE_3:  result = {1'b1, 4'd3};
      CODE_4:  result = {1'b1, 4'd4};
      CODE_5:  result = {1'b1, 4'd5};
      CODE_6:  result = {1'b1, 4'd6};
      CODE_7:  result = {1'b1, 4'd7};
      CODE_8:  result = {1'b1, 4'd8};
      CODE_9:  result = {1'b1, 4'd9};
      default: result = {1'b0, INVALID_DIGIT};
    endcase
    return result;
  endfunction

endpackage : tof5_pkg
`default_nettype wire

// File: rtl/tof5_frame_decoder_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tof5_frame_decoder_if                                           |
// | Purpose  : Valid/ready bundle for the frame decoder: codeword input stream |
// |            and packed-BCD frame output stream.                             |
// | Ports    : in_valid/in_ready/in_code/in_last   - codeword beat stream      |
// |            out_valid/out_ready/out_bcd/out_cnt/out_err - frame stream      |
// |            modport master : producer of beats / consumer of frames         |
// |            modport slave  : the decoder itself                             |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface tof5_frame_decoder_if
  import tof5_pkg::*;
#(
  parameter int NDIG = NDIG_DEFAULT
);

  localparam int CW = $clog2(NDIG + 1);

  logic              in_valid;
  logic              in_ready;
  logic [4:0]        in_code;
  logic              in_last;

  logic              out_valid;
  logic              out_ready;
  logic [4*NDIG-1:0] out_bcd;
  logic [CW-1:0]     out_cnt;
  logic              out_err;

  modport master (
    output in_valid, in_code, in_last, out_ready,
    input  in_ready, out_valid, out_bcd, out_cnt, out_err
  );

  modport slave (
    input  in_valid, in_code, in_last, out_ready,
    output in_ready, out_valid, out_bcd, out_cnt, out_err
  );

endinterface : tof5_frame_decoder_if
`default_nettype wire

// File: rtl/tof5_digit_decode.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tof5_digit_decode                                               |
// | Purpose  : Combinational 2-out-of-5 codeword to BCD digit decoder.         |
// | Ports    : code    in  5 - received codeword                               |
// |            digit   out 4 - decoded digit, INVALID_DIGIT when not code_ok   |
// |            code_ok out 1 - weight is exactly two and codeword is mapped    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tof5_digit_decode
  import tof5_pkg::*;
(
  input  logic [4:0] code,
  output logic [3:0] digit,
  output logic       code_ok
);

  logic [4:0] w_lookup;

  assign w_lookup = tof5_decode(code);

  // Every weight-2 word is in the map, but the weight test is kept explicit so
  // a corrupted table cannot silently admit a bad codeword.
  assign code_ok  = w_lookup[4] && ($countones(code) == 2);
  assign digit    = code_ok ? w_lookup[3:0] : INVALID_DIGIT;

endmodule : tof5_digit_decode
`default_nettype wire

// File: rtl/tof5_frame_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tof5_frame_decoder                                              |
// | Purpose  : Decodes a stream of 2-out-of-5 codewords into BCD digits, packs |
// |            up to NDIG digits per frame into one word and counts code       |
// |            violations.                                                     |
// | Ports    : clk     in  1    - rising-edge clock                            |
// |            rst_n   in  1    - asynchronous active-low reset                |
// |            bus     slave    - beat input / frame output streams            |
// |            err_clr in  1    - synchronous clear of err_cnt                 |
// |            err_cnt out ERRW - saturating invalid-codeword count            |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tof5_frame_decoder
  import tof5_pkg::*;
#(
  parameter int NDIG = NDIG_DEFAULT,
  parameter int ERRW = 8
)(
  input  logic                 clk,
  input  logic                 rst_n,
  tof5_frame_decoder_if.slave  bus,
  input  logic                 err_clr,
  output logic [ERRW-1:0]      err_cnt
);

  localparam int              AW      = 4 * NDIG;
  localparam int              CW      = $clog2(NDIG + 1);
  localparam logic [ERRW-1:0] ERR_MAX = '1;

  state_t          r_state;
  logic [AW-1:0]   r_acc;
  logic [CW-1:0]   r_dcnt;
  logic            r_flag;

  logic            r_out_valid;
  logic [AW-1:0]   r_out_bcd;
  logic [CW-1:0]   r_out_cnt;
  logic            r_out_err;
  logic [ERRW-1:0] r_err_cnt;

  logic [3:0]      w_digit;
  logic            w_code_ok;
  logic            w_in_ready;
  logic            w_accept;
  logic            w_complete;
  logic [AW-1:0]   w_acc_base;
  logic [CW-1:0]   w_dcnt_base;
  logic [AW-1:0]   w_acc_next;
  logic [CW-1:0]   w_dcnt_next;
  logic            w_flag_next;

  tof5_digit_decode u_digit_decode (
    .code    (bus.in_code),
    .digit   (w_digit),
    .code_ok (w_code_ok)
  );

  // A frame slot frees up in the same cycle the consumer takes the pending one.
  assign w_in_ready = ~r_out_valid | bus.out_ready;
  assign w_accept   = bus.in_valid & w_in_ready;

  // IDLE always represents an empty frame, whatever the registers hold.
  assign w_acc_base  = (r_state == ST_IDLE) ? '0 : r_acc;
  assign w_dcnt_base = (r_state == ST_IDLE) ? '0 : r_dcnt;

  generate
    if (NDIG > 1) begin : g_shift_multi
      assign w_acc_next = {w_acc_base[AW-5:0], w_digit};
    end else begin : g_shift_single
      assign w_acc_next = w_digit;
    end
  endgenerate

  assign w_dcnt_next = w_dcnt_base + 1'b1;
  assign w_flag_next = r_flag | ~w_code_ok;

  // The NDIG-th digit closes the frame regardless of in_last.
  assign w_complete  = w_accept & (bus.in_last | (w_dcnt_base == CW'(NDIG - 1)));

  // Frame-collection FSM and accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_acc   <= '0;
      r_dcnt  <= '0;
      r_flag  <= 1'b0;
    end else if (w_accept) begin
      if (w_complete) begin
        r_state <= ST_IDLE;
        r_acc   <= '0;
        r_dcnt  <= '0;
        r_flag  <= 1'b0;
      end else begin
        r_state <= ST_COLLECT;
        r_acc   <= w_acc_next;
        r_dcnt  <= w_dcnt_next;
        r_flag  <= w_flag_next;
      end
    end
  end

  // Output register: a new frame wins over a simultaneous drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_bcd   <= '0;
      r_out_cnt   <= '0;
      r_out_err   <= 1'b0;
    end else if (w_complete) begin
      r_out_valid <= 1'b1;
      r_out_bcd   <= w_acc_next;
      r_out_cnt   <= w_dcnt_next;
      r_out_err   <= w_flag_next;
    end else if (r_out_valid && bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Violation counter: a clear coinciding with a bad beat counts that beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cnt <= '0;
    end else if (w_accept && !w_code_ok) begin
      if (err_clr) begin
        r_err_cnt <= ERRW'(1);
      end else if (r_err_cnt != ERR_MAX) begin
        r_err_cnt <= r_err_cnt + 1'b1;
      end
    end else if (err_clr) begin
      r_err_cnt <= '0;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_bcd   = r_out_bcd;
  assign bus.out_cnt   = r_out_cnt;
  assign bus.out_err   = r_out_err;
  assign err_cnt       = r_err_cnt;

endmodule : tof5_frame_decoder
`default_nettype wire

// File: tb/tb_tof5_frame_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_tof5_frame_decoder                                           |
// | Purpose  : Self-checking bench for tof5_frame_decoder: directed scenarios  |
// |            against fixed expected frames plus randomized traffic against a |
// |            queue-based reference model of framing and error counting.      |
// | Ports    : none                                                            |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_tof5_frame_decoder;

  localparam int NDIG = 4;
  localparam int ERRW = 8;
  localparam int CW   = 3;
  localparam int AW   = 4 * NDIG;

  logic            clk;
  logic            rst_n;
  logic            err_clr;
  logic [ERRW-1:0] err_cnt;

  tof5_frame_decoder_if #(.NDIG(NDIG)) bus ();

  tof5_frame_decoder #(.NDIG(NDIG), .ERRW(ERRW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .err_clr (err_clr),
    .err_cnt (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] bcd;
    logic [CW-1:0] cnt;
    logic          err;
  } frame_t;

  frame_t obs[$];
  frame_t expq[$];
  int     m_dig[$];
  bit     m_flag;
  int     m_err;
  int     checks;
  int     errors;

  logic [4:0] code_tab [0:9] = '{5'b00011, 5'b00101, 5'b00110, 5'b01001, 5'b01010,
                                 5'b01100, 5'b10001, 5'b10010, 5'b10100, 5'b11000};

  // Digit value for a codeword, 15 for anything that is not a table entry of weight 2.
  function automatic int ref_digit(input logic [4:0] c);
    int ones;
    ones = 0;
    for (int b = 0; b < 5; b++) ones += int'(c[b]);
    if (ones != 2) return 15;
    for (int i = 0; i < 10; i++) if (code_tab[i] == c) return i;
    return 15;
  endfunction

  task automatic model_reset();
    m_dig.delete();
    m_flag = 1'b0;
    m_err  = 0;
    expq.delete();
    obs.delete();
  endtask

  task automatic model_beat(input logic [4:0] c, input bit last, input bit clr);
    int d;
    d = ref_digit(c);
    m_dig.push_back(d);
    if (d == 15) begin
      m_flag = 1'b1;
      m_err  = clr ? 1 : ((m_err < 255) ? m_err + 1 : 255);
    end else if (clr) begin
      m_err = 0;
    end
    if (last || m_dig.size() == NDIG) begin
      frame_t f;
      f.bcd = '0;
      foreach (m_dig[i]) f.bcd = (f.bcd << 4) | AW'(m_dig[i]);
      f.cnt = CW'(m_dig.size());
      f.err = m_flag;
      expq.push_back(f);
      m_dig.delete();
      m_flag = 1'b0;
    end
  endtask

  // One clock cycle: drive at the falling edge, sample handshakes just after it,
  // return #1 past the rising edge so callers can look at registered outputs.
  task automatic cycle(input bit v, input logic [4:0] c, input bit last,
                       input bit ordy, input bit clr, output bit accepted);
    @(negedge clk);
    bus.in_valid  = v;
    bus.in_code   = c;
    bus.in_last   = last;
    bus.out_ready = ordy;
    err_clr       = clr;
    #1;
    accepted = v && (bus.in_ready === 1'b1);
    if (bus.out_valid === 1'b1 && ordy) begin
      frame_t f;
      f.bcd = bus.out_bcd;
      f.cnt = bus.out_cnt;
      f.err = bus.out_err;
      obs.push_back(f);
    end
    if (accepted) model_beat(c, last, clr);
    else if (clr) m_err = 0;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    err_clr      = 1'b0;
  endtask

  task automatic send(input logic [4:0] c, input bit last, input bit ordy);
    bit a;
    int n;
    a = 1'b0;
    n = 0;
    while (!a && n < 50) begin
      cycle(1'b1, c, last, ordy, 1'b0, a);
      n++;
    end
    if (!a) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: beat %b not accepted within 50 cycles", c);
    end
  endtask

  task automatic idle(input int n, input bit ordy);
    bit a;
    for (int i = 0; i < n; i++) cycle(1'b0, 5'b0, 1'b0, ordy, 1'b0, a);
  endtask

  task automatic hold_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
  endtask

  task automatic release_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    #1;
  endtask

  task automatic test_reset();
    checks += 6;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    if (bus.out_bcd !== 16'h0) begin errors++; $display("FAIL reset_out_bcd: got %h want 0000", bus.out_bcd); end
    if (bus.out_cnt !== 3'd0) begin errors++; $display("FAIL reset_out_cnt: got %0d want 0", bus.out_cnt); end
    if (bus.out_err !== 1'b0) begin errors++; $display("FAIL reset_out_err: got %b want 0", bus.out_err); end
    if (err_cnt !== 8'd0) begin errors++; $display("FAIL reset_err_cnt: got %0d want 0", err_cnt); end
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
  endtask

  task automatic test_full_frame();
    obs.delete();
    send(5'b01001, 1'b0, 1'b1);
    send(5'b01100, 1'b0, 1'b1);
    send(5'b10001, 1'b0, 1'b1);
    send(5'b11000, 1'b1, 1'b1);
    idle(2, 1'b1);
    checks += 2;
    if (obs.size() != 1) begin errors++; $display("FAIL full_frame_count: got %0d want 1", obs.size()); end
    if (err_cnt !== 8'd0) begin errors++; $display("FAIL full_frame_err_cnt: got %0d want 0", err_cnt); end
    if (obs.size() >= 1) begin
      checks++;
      if (obs[0].bcd !== 16'h3569 || obs[0].cnt !== 3'd4 || obs[0].err !== 1'b0) begin
        errors++;
        $display("FAIL full_frame_data: got bcd=%h cnt=%0d err=%b want 3569/4/0", obs[0].bcd, obs[0].cnt, obs[0].err);
      end
    end
  endtask

  task automatic test_short_frames();
    obs.delete();
    send(5'b00011, 1'b0, 1'b1);
    send(5'b10010, 1'b1, 1'b1);
    send(5'b00101, 1'b1, 1'b1);
    idle(2, 1'b1);
    checks++;
    if (obs.size() != 2) begin errors++; $display("FAIL short_count: got %0d want 2", obs.size()); end
    if (obs.size() >= 2) begin
      checks += 2;
      if (obs[0].bcd !== 16'h0007 || obs[0].cnt !== 3'd2) begin
        errors++; $display("FAIL short_two_digit: got bcd=%h cnt=%0d want 0007/2", obs[0].bcd, obs[0].cnt);
      end
      if (obs[1].bcd !== 16'h0001 || obs[1].cnt !== 3'd1) begin
        errors++; $display("FAIL short_one_digit: got bcd=%h cnt=%0d want 0001/1", obs[1].bcd, obs[1].cnt);
      end
    end
  endtask

  task automatic test_auto_close();
    obs.delete();
    for (int i = 0; i < 5; i++) send(5'b10100, 1'b0, 1'b1);
    idle(2, 1'b1);
    checks++;
    if (obs.size() != 1) begin errors++; $display("FAIL auto_close_count: got %0d want 1", obs.size()); end
    if (obs.size() >= 1) begin
      checks++;
      if (obs[0].bcd !== 16'h8888 || obs[0].cnt !== 3'd4) begin
        errors++; $display("FAIL auto_close_data: got bcd=%h cnt=%0d want 8888/4", obs[0].bcd, obs[0].cnt);
      end
    end
    send(5'b00011, 1'b1, 1'b1);
    idle(2, 1'b1);
    checks++;
    if (obs.size() != 2) begin errors++; $display("FAIL auto_close_next_count: got %0d want 2", obs.size()); end
    if (obs.size() >= 2) begin
      checks++;
      if (obs[1].bcd !== 16'h0080 || obs[1].cnt !== 3'd2) begin
        errors++; $display("FAIL auto_close_next_data: got bcd=%h cnt=%0d want 0080/2", obs[1].bcd, obs[1].cnt);
      end
    end
  endtask

  task automatic test_invalid();
    obs.delete();
    send(5'b00011, 1'b0, 1'b1);
    send(5'b00111, 1'b1, 1'b1);
    idle(2, 1'b1);
    checks++;
    if (err_cnt !== 8'd1) begin errors++; $display("FAIL invalid_err_cnt: got %0d want 1", err_cnt); end
    send(5'b00101, 1'b1, 1'b1);
    idle(2, 1'b1);
    checks++;
    if (obs.size() != 2) begin errors++; $display("FAIL invalid_count: got %0d want 2", obs.size()); end
    if (obs.size() >= 2) begin
      checks += 2;
      if (obs[0].bcd !== 16'h000F || obs[0].cnt !== 3'd2 || obs[0].err !== 1'b1) begin
        errors++; $display("FAIL invalid_frame: got bcd=%h cnt=%0d err=%b want 000F/2/1", obs[0].bcd, obs[0].cnt, obs[0].err);
      end
      if (obs[1].bcd !== 16'h0001 || obs[1].err !== 1'b0) begin
        errors++; $display("FAIL invalid_clean_after: got bcd=%h err=%b want 0001/0", obs[1].bcd, obs[1].err);
      end
    end
  endtask

  task automatic test_backpressure();
    bit a;
    obs.delete();
    send(5'b11000, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 5'b00101, 1'b0, 1'b0, 1'b0, a);
      checks += 3;
      if (a !== 1'b0) begin errors++; $display("FAIL bp_blocked: beat accepted=%b want 0", a); end
      if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_hold: got %b want 1", bus.out_valid); end
      if (bus.out_bcd !== 16'h0009) begin errors++; $display("FAIL bp_data_stable: got %h want 0009", bus.out_bcd); end
    end
    cycle(1'b1, 5'b10100, 1'b1, 1'b1, 1'b0, a);
    checks += 4;
    if (a !== 1'b1) begin errors++; $display("FAIL bp_release_accept: got %b want 1", a); end
    if (obs.size() != 1) begin errors++; $display("FAIL bp_drain_count: got %0d want 1", obs.size()); end
    if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_reload_valid: got %b want 1", bus.out_valid); end
    if (bus.out_bcd !== 16'h0008 || bus.out_cnt !== 3'd1) begin
      errors++; $display("FAIL bp_reload_data: got bcd=%h cnt=%0d want 0008/1", bus.out_bcd, bus.out_cnt);
    end
    idle(2, 1'b1);
    checks++;
    if (obs.size() != 2) begin errors++; $display("FAIL bp_final_count: got %0d want 2", obs.size()); end
  endtask

  task automatic test_err_saturation();
    bit a;
    cycle(1'b0, 5'b0, 1'b0, 1'b1, 1'b1, a);
    checks++;
    if (err_cnt !== 8'd0) begin errors++; $display("FAIL sat_clear: got %0d want 0", err_cnt); end
    for (int i = 0; i < 300; i++) send(5'b00000, 1'b1, 1'b1);
    checks++;
    if (err_cnt !== 8'd255) begin errors++; $display("FAIL sat_max: got %0d want 255", err_cnt); end
    cycle(1'b1, 5'b11111, 1'b1, 1'b1, 1'b1, a);
    checks++;
    if (err_cnt !== 8'd1) begin errors++; $display("FAIL sat_clr_with_bad: got %0d want 1", err_cnt); end
    cycle(1'b0, 5'b0, 1'b0, 1'b1, 1'b1, a);
    checks++;
    if (err_cnt !== 8'd0) begin errors++; $display("FAIL sat_clr_alone: got %0d want 0", err_cnt); end
    idle(2, 1'b1);
  endtask

  task automatic test_random();
    bit         a;
    bit         v;
    bit         last;
    bit         ordy;
    bit         clr;
    logic [4:0] c;
    int         n;
    obs.delete();
    expq.delete();
    for (int i = 0; i < 3000; i++) begin
      v    = ($urandom_range(0, 3) != 0);
      c    = ($urandom_range(0, 7) == 0) ? 5'($urandom) : code_tab[$urandom_range(0, 9)];
      last = ($urandom_range(0, 3) == 0);
      ordy = ($urandom_range(0, 3) != 0);
      clr  = ($urandom_range(0, 63) == 0);
      cycle(v, c, last, ordy, clr, a);
      checks++;
      if (err_cnt !== ERRW'(m_err)) begin
        errors++; $display("FAIL rand_err_cnt: cycle %0d got %0d want %0d", i, err_cnt, m_err);
      end
    end
    send(5'b01010, 1'b1, 1'b1);
    idle(3, 1'b1);
    checks++;
    if (obs.size() != expq.size()) begin
      errors++; $display("FAIL rand_frame_count: got %0d want %0d", obs.size(), expq.size());
    end
    n = (obs.size() < expq.size()) ? obs.size() : expq.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      if (obs[i].bcd !== expq[i].bcd || obs[i].cnt !== expq[i].cnt || obs[i].err !== expq[i].err) begin
        errors++;
        $display("FAIL rand_frame[%0d]: got bcd=%h cnt=%0d err=%b want bcd=%h cnt=%0d err=%b",
                 i, obs[i].bcd, obs[i].cnt, obs[i].err, expq[i].bcd, expq[i].cnt, expq[i].err);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    send(5'b00101, 1'b0, 1'b1);
    send(5'b00110, 1'b0, 1'b1);
    hold_reset();
    checks += 4;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b want 0", bus.out_valid); end
    if (bus.out_bcd !== 16'h0 || bus.out_cnt !== 3'd0 || bus.out_err !== 1'b0) begin
      errors++; $display("FAIL midrst_data: got bcd=%h cnt=%0d err=%b want 0", bus.out_bcd, bus.out_cnt, bus.out_err);
    end
    if (err_cnt !== 8'd0) begin errors++; $display("FAIL midrst_err_cnt: got %0d want 0", err_cnt); end
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready: got %b want 1", bus.in_ready); end
    release_reset();
    send(5'b01001, 1'b1, 1'b1);
    idle(2, 1'b1);
    checks++;
    if (obs.size() != 1) begin errors++; $display("FAIL midrst_partial_count: got %0d want 1", obs.size()); end
    if (obs.size() >= 1) begin
      checks++;
      if (obs[0].bcd !== 16'h0003 || obs[0].cnt !== 3'd1) begin
        errors++; $display("FAIL midrst_partial_drop: got bcd=%h cnt=%0d want 0003/1", obs[0].bcd, obs[0].cnt);
      end
    end
    send(5'b01010, 1'b1, 1'b0);
    checks++;
    if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL midrst_pending: got %b want 1", bus.out_valid); end
    hold_reset();
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_pending_drop: got %b want 0", bus.out_valid); end
    release_reset();
    idle(3, 1'b1);
    checks++;
    if (obs.size() != 0) begin errors++; $display("FAIL midrst_spurious: got %0d frames want 0", obs.size()); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    checks        = 0;
    errors        = 0;
    rst_n         = 1'b0;
    err_clr       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_code   = 5'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    model_reset();
    release_reset();

    test_reset();
    test_full_frame();
    test_short_frames();
    test_auto_close();
    test_invalid();
    test_backpressure();
    test_err_saturation();
    test_random();
    test_reset_mid_frame();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_tof5_frame_decoder
`default_nettype wire
